// File: rtl/calc_sequencer_pkg.sv
// Shared encodings for the calculator control sequencer:
// alu modes, FSM states and display phase codes.
package calc_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_MUL = 3'b010;
    localparam logic [2:0] ALU_DIV = 3'b011;
    localparam logic [2:0] ALU_NOP = 3'b100;

    typedef enum logic [2:0] {
        GET_A = 3'd0,
        GET_B = 3'd1,
        EXEC  = 3'd2,
        DIV   = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [1:0] PH_GET_A = 2'd0;
    localparam logic [1:0] PH_GET_B = 2'd1;
    localparam logic [1:0] PH_BUSY  = 2'd2;
    localparam logic [1:0] PH_DONE  = 2'd3;

endpackage

// File: rtl/calc_sequencer_if.sv
// Bus between the calculator sequencer (master) and the shared alu (slave).
interface calc_sequencer_if #(
    parameter int W = 16
);

    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [2:0]   alu_mode;
    logic [W-1:0] alu_out;
    logic         alu_neg;

    modport master (
        output alu_a, alu_b, alu_mode,
        input  alu_out, alu_neg
    );

    modport slave (
        input  alu_a, alu_b, alu_mode,
        output alu_out, alu_neg
    );

endinterface

// File: rtl/calc_sequencer.sv
// Calculator control FSM: collects A, B and op, drives the shared alu
// and performs DIV as a restoring division using one alu SUB per cycle.
module calc_sequencer #(
    parameter int OPW = 8,
    parameter int W   = 16,
    parameter int CW  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [OPW-1:0]        sw_val,
    input  logic [1:0]            op,
    input  logic                  enter,
    input  logic                  clear,
    calc_sequencer_if.master      alu,
    output logic [W-1:0]          result,
    output logic                  result_neg,
    output logic [OPW-1:0]        remainder,
    output logic                  err,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            phase
);

    import calc_pkg::*;

    state_t         state, state_n;
    logic [OPW-1:0] a_reg, a_n;
    logic [OPW-1:0] b_reg, b_n;
    logic [1:0]     op_reg, op_n;
    logic [OPW-1:0] q, q_n;
    logic [OPW-1:0] rq, rq_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [W-1:0]   res_n;
    logic [OPW-1:0] rem_n;
    logic           neg_n, err_n, done_n;
    logic [W-1:0]   sub_a;

    // partial remainder stays below b, so OPW bits hold it
    assign sub_a = W'({rq, a_reg[cnt]});

    assign busy = (state == EXEC) || (state == DIV);

    always_comb begin
        phase = PH_GET_A;
        unique case (state)
            GET_A:     phase = PH_GET_A;
            GET_B:     phase = PH_GET_B;
            EXEC, DIV: phase = PH_BUSY;
            DONE:      phase = PH_DONE;
            default:   phase = PH_GET_A;
        endcase
    end

    always_comb begin
        state_n      = state;
        a_n          = a_reg;
        b_n          = b_reg;
        op_n         = op_reg;
        q_n          = q;
        rq_n         = rq;
        cnt_n        = cnt;
        res_n        = result;
        neg_n        = result_neg;
        rem_n        = remainder;
        err_n        = err;
        done_n       = 1'b0;
        alu.alu_mode = ALU_NOP;
        alu.alu_a    = '0;
        alu.alu_b    = '0;
        unique case (state)
            GET_A: begin
                if (enter) begin
                    a_n     = sw_val;
                    state_n = GET_B;
                end
            end
            GET_B: begin
                if (enter) begin
                    b_n  = sw_val;
                    op_n = op;
                    if (op != 2'b11) begin
                        state_n = EXEC;
                    end else if (sw_val == '0) begin
                        state_n = DONE;
                        err_n   = 1'b1;
                        res_n   = '0;
                        rem_n   = '0;
                        neg_n   = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        state_n = DIV;
                        cnt_n   = CW'(OPW - 1);
                        rq_n    = '0;
                        q_n     = '0;
                    end
                end
            end
            EXEC: begin
                alu.alu_mode = {1'b0, op_reg};
                alu.alu_a    = W'(a_reg);
                alu.alu_b    = W'(b_reg);
                res_n        = alu.alu_out;
                neg_n        = (op_reg == 2'b10) ? 1'b0 : alu.alu_neg;
                rem_n        = '0;
                state_n      = DONE;
                done_n       = 1'b1;
            end
            DIV: begin
                alu.alu_mode = ALU_SUB;
                alu.alu_a    = sub_a;
                alu.alu_b    = W'(b_reg);
                rq_n = alu.alu_neg ? sub_a[OPW-1:0]
                                   : alu.alu_out[OPW-1:0];
                q_n[cnt] = ~alu.alu_neg;
                if (cnt == '0) begin
                    res_n   = W'(q_n);
                    rem_n   = rq_n;
                    neg_n   = 1'b0;
                    state_n = DONE;
                    done_n  = 1'b1;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            DONE: begin
                if (enter) begin
                    state_n = GET_A;
                    err_n   = 1'b0;
                end
            end
            default: state_n = GET_A;
        endcase
        if (clear) begin
            state_n = GET_A;
            a_n     = '0;
            b_n     = '0;
            op_n    = '0;
            q_n     = '0;
            rq_n    = '0;
            cnt_n   = '0;
            res_n   = '0;
            neg_n   = 1'b0;
            rem_n   = '0;
            err_n   = 1'b0;
            done_n  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= GET_A;
            a_reg      <= '0;
            b_reg      <= '0;
            op_reg     <= '0;
            q          <= '0;
            rq         <= '0;
            cnt        <= '0;
            result     <= '0;
            result_neg <= 1'b0;
            remainder  <= '0;
            err        <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            a_reg      <= a_n;
            b_reg      <= b_n;
            op_reg     <= op_n;
            q          <= q_n;
            rq         <= rq_n;
            cnt        <= cnt_n;
            result     <= res_n;
            result_neg <= neg_n;
            remainder  <= rem_n;
            err        <= err_n;
            done       <= done_n;
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: vector table with a done-driven
// scoreboard, plus hand sequences for clear mid-DIV and async reset.
module tb_calc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  sw_val = '0;
    logic [1:0]  op = '0;
    logic        enter = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] result;
    logic        result_neg;
    logic [7:0]  remainder;
    logic        err, busy, done;
    logic [1:0]  phase;

    calc_sequencer_if #(.W(16)) bus ();

    calc_sequencer #(.OPW(8), .W(16), .CW(3)) dut (
        .clk(clk), .rst_n(rst_n), .sw_val(sw_val), .op(op),
        .enter(enter), .clear(clear), .alu(bus),
        .result(result), .result_neg(result_neg),
        .remainder(remainder), .err(err), .busy(busy),
        .done(done), .phase(phase)
    );

    // reference alu: magnitude result plus a negative flag for SUB
    always_comb begin
        bus.alu_out = '0;
        bus.alu_neg = 1'b0;
        case (bus.alu_mode)
            3'b000: bus.alu_out = bus.alu_a + bus.alu_b;
            3'b001: begin
                if (bus.alu_a < bus.alu_b) begin
                    bus.alu_out = bus.alu_b - bus.alu_a;
                    bus.alu_neg = 1'b1;
                end else begin
                    bus.alu_out = bus.alu_a - bus.alu_b;
                end
            end
            3'b010: bus.alu_out = bus.alu_a * bus.alu_b;
            default: ;
        endcase
    end

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [1:0]  op;
        logic [7:0]  b;
        logic [15:0] res;
        logic        neg;
        logic [7:0]  rem;
        logic        err;
        int          lat;
    } vec_t;

    typedef struct {
        logic [15:0] res;
        logic        neg;
        logic [7:0]  rem;
        logic        err;
        logic [2:0]  mode;
        int          dcyc;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   bcnt = 0;
    bit   sb_on = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, req,
                     $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb_on && rst_n) begin
            if (busy && exp_q.size() > 0) begin
                chk("busy_mode", {29'd0, bus.alu_mode}, {29'd0, exp_q[0].mode});
                bcnt++;
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("result", {16'd0, result}, {16'd0, e.res});
                    chk("result_neg", {31'd0, result_neg}, {31'd0, e.neg});
                    chk("remainder", {24'd0, remainder}, {24'd0, e.rem});
                    chk("err", {31'd0, err}, {31'd0, e.err});
                    chk("latency", cyc, e.dcyc);
                    chk("busy_cycles", bcnt, e.lat - 1);
                end
                bcnt = 0;
            end
        end
    end

    task automatic run_vec(input vec_t v);
        exp_t e;
        @(negedge clk);
        sw_val = v.a;
        enter = 1'b1;
        @(negedge clk);
        enter = 1'b0;
        @(negedge clk);
        sw_val = v.b;
        op = v.op;
        enter = 1'b1;
        e.res  = v.res;
        e.neg  = v.neg;
        e.rem  = v.rem;
        e.err  = v.err;
        e.mode = (v.op == 2'b11) ? 3'b001 : {1'b0, v.op};
        e.dcyc = cyc + v.lat;
        e.lat  = v.lat;
        bcnt = 0;
        exp_q.push_back(e);
        @(negedge clk);
        enter = 1'b0;
        op = ~v.op;
        sw_val = ~v.b;
        if (v.lat == 9) begin
            @(negedge clk);
            enter = 1'b1;
            @(negedge clk);
            enter = 1'b0;
        end
        for (int k = 0; k < 20; k++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            chk("done_timeout", 32'd0, 32'd1);
            exp_q.delete();
        end
        @(negedge clk);
        enter = 1'b1;
        @(negedge clk);
        enter = 1'b0;
        chk("back_to_get_a", {30'd0, phase}, 32'd0);
        chk("err_cleared", {31'd0, err}, 32'd0);
    endtask

    vec_t tbl[12];
    vec_t extra;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{8'd200, 2'b00, 8'd100, 16'd300,   1'b0, 8'd0, 1'b0, 2};
        tbl[1]  = '{8'd5,   2'b01, 8'd9,   16'd4,     1'b1, 8'd0, 1'b0, 2};
        tbl[2]  = '{8'd9,   2'b01, 8'd5,   16'd4,     1'b0, 8'd0, 1'b0, 2};
        tbl[3]  = '{8'd255, 2'b10, 8'd255, 16'd65025, 1'b0, 8'd0, 1'b0, 2};
        tbl[4]  = '{8'd200, 2'b11, 8'd7,   16'd28,    1'b0, 8'd4, 1'b0, 9};
        tbl[5]  = '{8'd13,  2'b11, 8'd0,   16'd0,     1'b0, 8'd0, 1'b1, 1};
        tbl[6]  = '{8'd255, 2'b11, 8'd1,   16'd255,   1'b0, 8'd0, 1'b0, 9};
        tbl[7]  = '{8'd7,   2'b11, 8'd9,   16'd0,     1'b0, 8'd7, 1'b0, 9};
        tbl[8]  = '{8'd255, 2'b11, 8'd255, 16'd1,     1'b0, 8'd0, 1'b0, 9};
        tbl[9]  = '{8'd100, 2'b01, 8'd100, 16'd0,     1'b0, 8'd0, 1'b0, 2};
        tbl[10] = '{8'd1,   2'b11, 8'd255, 16'd0,     1'b0, 8'd1, 1'b0, 9};
        tbl[11] = '{8'd255, 2'b00, 8'd255, 16'd510,   1'b0, 8'd0, 1'b0, 2};
        extra   = '{8'd200, 2'b11, 8'd7,   16'd28,    1'b0, 8'd4, 1'b0, 9};

        // reset state
        #12;
        chk("rst_phase", {30'd0, phase}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_mode", {29'd0, bus.alu_mode}, 32'd4);
        chk("rst_alu_a", {16'd0, bus.alu_a}, 32'd0);
        chk("rst_result", {16'd0, result}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        sb_on = 1'b1;
        for (int i = 0; i < 12; i++) run_vec(tbl[i]);
        sb_on = 1'b0;

        // async reset while in EXEC
        @(negedge clk);
        sw_val = 8'd10;
        enter = 1'b1;
        @(negedge clk);
        enter = 1'b0;
        @(negedge clk);
        sw_val = 8'd20;
        op = 2'b00;
        enter = 1'b1;
        @(negedge clk);
        enter = 1'b0;
        chk("exec_busy", {31'd0, busy}, 32'd1);
        chk("exec_mode", {29'd0, bus.alu_mode}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_phase", {30'd0, phase}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_mode", {29'd0, bus.alu_mode}, 32'd4);
        chk("arst_alu_a", {16'd0, bus.alu_a}, 32'd0);
        chk("arst_result", {16'd0, result}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        sb_on = 1'b1;
        run_vec(extra);
        sb_on = 1'b0;

        // clear on the 4th DIV cycle
        @(negedge clk);
        sw_val = 8'd255;
        enter = 1'b1;
        @(negedge clk);
        enter = 1'b0;
        @(negedge clk);
        sw_val = 8'd1;
        op = 2'b11;
        enter = 1'b1;
        @(negedge clk);
        enter = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("div4_mode", {29'd0, bus.alu_mode}, 32'd1);
        chk("div4_busy", {31'd0, busy}, 32'd1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clr_phase", {30'd0, phase}, 32'd0);
        chk("clr_busy", {31'd0, busy}, 32'd0);
        chk("clr_mode", {29'd0, bus.alu_mode}, 32'd4);
        chk("clr_result", {16'd0, result}, 32'd0);
        chk("clr_remainder", {24'd0, remainder}, 32'd0);
        begin
            int seen = 0;
            for (int k = 0; k < 12; k++) begin
                if (done) seen++;
                @(negedge clk);
            end
            chk("clr_no_done", seen, 32'd0);
        end
        chk("clr_idle_phase", {30'd0, phase}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
